// File: rtl/rf_port_pkg.sv
// Shared register-file port definitions: default widths and the read response entry.
package rf_port_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rd_rsp_t;
endpackage

// File: rtl/read_port_rsp_fifo.sv
// Response FIFO: circular buffer with modulo-DEPTH pointers and an occupancy count.
module rsp_fifo import rf_port_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = rd_rsp_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign do_pop = pop & ~empty;
  // Head is forced to zero when empty so the idle/reset output is clean.
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/read_port.sv
// Register-file read port: S1 read stage with write forwarding, credit-gated accept, response FIFO.
module read_port import rf_port_pkg::*; #(
  parameter int DATA_W   = rf_port_pkg::DATA_W,
  parameter int ADDR_W   = rf_port_pkg::ADDR_W,
  parameter int DEPTH    = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic              accept, pop;
  logic              s1_valid, s1_fwd;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_fwd_data, s1_res;
  logic [CW-1:0]     count;
  logic [CW:0]       inflight;
  logic              fifo_full, fifo_empty;
  rsp_t              push_ent, head;

  // Credit counts the S1 read as already occupying a slot, so a push never finds the FIFO full.
  assign inflight  = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign req_ready = (inflight < DEPTH_C);
  assign accept    = req_valid & req_ready;
  assign rf_en     = accept;
  assign rf_addr   = req_addr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid    <= 1'b0;
      s1_fwd      <= 1'b0;
      s1_addr     <= '0;
      s1_fwd_data <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr     <= req_addr;
        s1_fwd      <= wr_en & (wr_addr == req_addr);
        s1_fwd_data <= wr_data;
      end
    end
  end

  // Zero register overrides forwarding; forwarding covers the array's read-before-write.
  always_comb begin
    s1_res = s1_fwd ? s1_fwd_data : rf_rdata;
    if (ZERO_REG && s1_addr == '0) s1_res = '0;
  end

  assign push_ent = '{addr: s1_addr, data: s1_res};
  assign pop      = rsp_valid & rsp_ready;

  rsp_fifo #(.DEPTH(DEPTH), .T(rsp_t)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (s1_valid),
    .push_data (push_ent),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_data  = head.data;
  assign rsp_addr  = head.addr;

  always_ff @(posedge clk) begin
    if (rstn && s1_valid) assert (!fifo_full);
  end
endmodule

// File: tb/tb_read_port.sv
// Randomized and directed bench for read_port against a queue-based transaction model.
module tb_read_port;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          rf_en;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_rdata = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;

  read_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rf_en(rf_en), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr)
  );

  always #5 clk = ~clk;

  // Register array: synchronous read returning the pre-write value, write commits at the edge.
  logic [DW-1:0] mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (rf_en) rf_rdata <= mem[rf_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  int vectors = 0, miscompares = 0;
  int now = 0, n_acc = 0, n_pop = 0;
  bit last_acc = 0;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: a read returns the register value including a same-cycle write,
  // appears two cycles after acceptance at the earliest, in order, with at most DEPTH outstanding.
  task automatic model_step();
    bit   exp_ready, exp_valid, acc;
    exp_t e;
    if (!rstn) begin
      q.delete();
      last_acc = 0;
      return;
    end
    exp_ready = (q.size() < DEPTH);
    exp_valid = (q.size() > 0) && (q[0].c + 2 <= now);
    acc = req_valid && exp_ready;
    chk("req_ready", req_ready, exp_ready);
    chk("rf_en", rf_en, acc);
    if (req_valid) chk("rf_addr", rf_addr, req_addr);
    chk("rsp_valid", rsp_valid, exp_valid);
    chk("no_push_full", dut.u_fifo.push & dut.u_fifo.full, 0);
    if (exp_valid) begin
      chk("rsp_addr", rsp_addr, q[0].a);
      chk("rsp_data", rsp_data, q[0].d);
      if (rsp_ready) begin
        void'(q.pop_front());
        n_pop++;
      end
    end
    if (acc) begin
      e.a = req_addr;
      e.d = (req_addr == 0) ? '0 : (wr_en && wr_addr == req_addr) ? wr_data : mem[req_addr];
      e.c = now;
      q.push_back(e);
      n_acc++;
    end
    last_acc = acc;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    wr_en = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int k = 0;
    rsp_ready = 1;
    req_valid = 0;
    wr_en = 0;
    while ((q.size() > 0) && k < 50) begin cycle(); k++; end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int a0, p0, a;
    rstn = 0;
    cycle(); cycle();
    rstn = 1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_req_ready", req_ready, 1);

    // Basic read
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    cycle();
    wr_en = 0; rsp_ready = 1;
    req_valid = 1; req_addr = 5;
    cycle();
    req_valid = 0;
    chk("lat_t1_valid", rsp_valid, 0);
    cycle();
    chk("basic_valid", rsp_valid, 1);
    chk("basic_data", rsp_data, 32'hDEADBEEF);
    chk("basic_addr", rsp_addr, 5);
    idle(2);

    // Forward, then a later write must not leak in
    req_valid = 1; req_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h1234;
    cycle();
    req_valid = 0; wr_data = 32'h5555;
    cycle();
    wr_en = 0;
    chk("fwd_data", rsp_data, 32'h1234);
    idle(2);

    // Zero register
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF;
    cycle();
    wr_en = 0; req_valid = 1; req_addr = 0;
    cycle();
    req_valid = 0;
    cycle();
    chk("zero_valid", rsp_valid, 1);
    chk("zero_data", rsp_data, 0);
    idle(2);

    // Backpressure
    rsp_ready = 0; a = 1; a0 = n_acc; p0 = n_pop;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1; req_addr = AW'(a);
      cycle();
      if (last_acc) a++;
    end
    chk("bp_accepted", n_acc - a0, 4);
    chk("bp_ready_low", req_ready, 0);
    rsp_ready = 1;
    cycle();
    if (last_acc) a++;
    chk("bp_ready_rise", req_ready, 1);
    for (int i = 0; i < 20 && a <= 6; i++) begin
      req_addr = AW'(a);
      cycle();
      if (last_acc) a++;
    end
    drain();
    chk("bp_pops", n_pop - p0, 6);

    // Streaming
    rsp_ready = 1; a0 = n_acc; p0 = n_pop;
    for (int i = 0; i < 32; i++) begin
      req_valid = 1; req_addr = AW'($urandom_range(1, 15));
      cycle();
    end
    chk("stream_acc", n_acc - a0, 32);
    idle(2);
    chk("stream_pops", n_pop - p0, 32);

    // Reset mid-operation
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin req_valid = 1; req_addr = AW'(i + 7); cycle(); end
    req_valid = 0;
    rstn = 0;
    cycle();
    rstn = 1;
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_rsp_data", rsp_data, 0);
    rsp_ready = 1;
    idle(5);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = AW'($urandom);
      wr_en     = ($urandom_range(0, 1) != 0);
      wr_addr   = ($urandom_range(0, 1) != 0) ? req_addr : AW'($urandom);
      wr_data   = $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
      rstn      = ($urandom_range(0, 199) != 0);
      cycle();
      rstn = 1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/read_port.md
# read_port

Register-file read port that pairs with the existing registered write port. It accepts read requests over a valid/ready handshake and issues them to a register array with 1-cycle synchronous read latency. It forwards same-cycle writes so reads are never stale, and returns responses through a small FIFO so the consumer can stall without losing data. It sits between the datapath (operand fetch) and the register array.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 4, register index width (16 registers)
- `DEPTH`, 4, response FIFO entries; power of two, 2..8
- `ZERO_REG`, 1, when 1 register 0 always reads as 0
- `clk` in 1: single clock, all state updates on posedge
- `rstn` in 1: reset, synchronous, active-low
- `req_valid` in 1: read request present
- `req_ready` out 1: port can accept a request this cycle
- `req_addr` in ADDR_W: register index to read
- `rf_en` out 1: read strobe to the array; equals `req_valid & req_ready`
- `rf_addr` out ADDR_W: equals `req_addr`, combinational
- `rf_rdata` in DATA_W: array data, valid the cycle after `rf_en`
- `wr_en` in 1: write-port commit this cycle (snooped)
- `wr_addr` in ADDR_W: write-port index
- `wr_data` in DATA_W: write-port data
- `rsp_valid` out 1: FIFO head holds a response
- `rsp_ready` in 1: consumer takes the head
- `rsp_data` out DATA_W: read data at FIFO head
- `rsp_addr` out ADDR_W: index the head response belongs to

## Operation
- Accept: `req_valid & req_ready`. S1 captures `s1_valid=1`, `s1_addr=req_addr`, and `s1_fwd = wr_en & (wr_addr==req_addr)` with `s1_fwd_data=wr_data`.
- S1 cycle: result is `s1_fwd_data` if `s1_fwd`, else `rf_rdata`. If `ZERO_REG && s1_addr==0`, the result is 0; this overrides forwarding. The result is pushed into the FIFO at the end of the S1 cycle.
- Writes committed after the accept cycle do not affect an accepted read.
- Credit rule: `req_ready = (s1_valid + count) < DEPTH`. It is a function of registered state only, with no path from `rsp_ready`.
- FIFO: circular buffer with `rd_ptr`, `wr_ptr` of width log2(DEPTH), wrapping modulo DEPTH, and a `count` of width log2(DEPTH)+1.
  - Pop: `rsp_valid & rsp_ready`.
  - Push and pop in the same cycle leaves `count` unchanged. Pop from the head is allowed even when `count==DEPTH`.
  - Push when full cannot occur because of the credit rule. The bench asserts this.
- `rsp_valid = (count != 0)`. `rsp_data` and `rsp_addr` show the head entry, and must hold stable while `rsp_valid & !rsp_ready`.
- Responses are returned strictly in request order.

## Timing
- Latency: accept at cycle t gives `rsp_valid` at t+2 when the FIFO is empty.
- Throughput: one request per cycle sustained while `rsp_ready=1`, for `DEPTH>=3`.
- Reset (`rstn=0` at a posedge):
  - `s1_valid=0`, `count=0`, pointers 0, so `rsp_valid=0`, `rsp_data=0`, `rsp_addr=0`.
  - `req_ready=1` from the first cycle after reset.
  - `rf_en` follows `req_valid`.
- Reset mid-operation drops the in-flight S1 read and all FIFO entries. No response is emitted for them.
- Backpressure: with `rsp_ready=0`, `req_ready` falls after DEPTH accepted requests. It rises again the cycle after the first pop.

## Structure
- Package `rf_port_pkg`: `DATA_W`, `ADDR_W` defaults and a `rd_rsp_t` struct `{addr, data}`. The same package is shared with the write port and the register array.
- One sub-module, `rsp_fifo` (parameterised by DEPTH and entry type). It holds the pointers, count, and storage, and exposes push, pop, full, empty, and count.
- The top level holds the S1 stage, the forward/zero mux, and the credit logic.

## Test plan
- Basic read: preload r5=0xDEADBEEF, request addr 5 with `rsp_ready=1` -> `rsp_valid` 2 cycles later, `rsp_data=0xDEADBEEF`, `rsp_addr=5`.
- Forward: in the accept cycle for addr 3 drive `wr_en=1`, `wr_addr=3`, `wr_data=0x1234` with the array holding 0 -> response 0x1234. A write to addr 3 one cycle later does not change that response.
- Zero register: write 0xFFFF to r0, then read addr 0 -> response 0.
- Backpressure/full: `rsp_ready=0`, issue 6 back-to-back requests (addr 1..6) -> exactly 4 accepted and `req_ready=0`. Then raise `rsp_ready` -> responses 1..6 in order, none lost or duplicated.
- Streaming: 32 back-to-back reads with `rsp_ready=1` -> one response per cycle, `req_ready` never drops.
- Reset mid-operation: 3 requests outstanding, pull `rstn` low for one cycle -> `rsp_valid=0` and `req_ready=1` the next cycle, and no stale responses afterwards.
